// File: rtl/serial_add_sequencer.sv
// Bit-serial add sequencer: feeds operands LSB-first to an external 1-bit adder,
// collects sum bits, and presents the full result with carry-out and signed overflow.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             bit_valid,
  output logic             a_bit,
  output logic             b_bit,
  output logic             c_bit,
  input  logic             sum_bit,
  input  logic             carry_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_a_msb, r_b_msb, r_cout, r_ovf;
  logic             r_in_ready, r_bit_valid, r_out_valid, r_busy;
  logic             w_last;

  assign w_last = (r_cnt == CW'(WIDTH-1));

  // r_carry holds the latched carry-in for bit 0, then each registered carry-out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_bit_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a_sr      <= in_a;
          r_b_sr      <= in_b;
          r_carry     <= in_cin;
          r_a_msb     <= in_a[WIDTH-1];
          r_b_msb     <= in_b[WIDTH-1];
          r_cnt       <= '0;
          r_state     <= SHIFT;
          r_in_ready  <= 1'b0;
          r_bit_valid <= 1'b1;
          r_busy      <= 1'b1;
        end
        SHIFT: begin
          r_sum[r_cnt] <= sum_bit;
          r_carry      <= carry_bit;
          r_a_sr       <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr       <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cnt        <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= DONE;
            r_bit_valid <= 1'b0;
            r_out_valid <= 1'b1;
            r_cout      <= carry_bit;
            r_ovf       <= (r_a_msb == r_b_msb) && (sum_bit != r_a_msb);
          end
        end
        DONE: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign bit_valid = r_bit_valid;
  assign a_bit     = r_bit_valid & r_a_sr[0];
  assign b_bit     = r_bit_valid & r_b_sr[0];
  assign c_bit     = r_bit_valid & r_carry;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized bench for serial_add_sequencer against an arithmetic reference model.
module tb_serial_add_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b;
  logic         bit_valid, a_bit, b_bit, c_bit, sum_bit, carry_bit;
  logic         out_valid, out_ready, out_cout, out_ovf, busy;
  logic [W-1:0] out_sum;

  int n_chk = 0;
  int n_err = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .c_bit(c_bit), .sum_bit(sum_bit),
    .carry_bit(carry_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  // External 1-bit full adder
  assign sum_bit   = a_bit ^ b_bit ^ c_bit;
  assign carry_bit = (a_bit & b_bit) | (a_bit & c_bit) | (b_bit & c_bit);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int stall);
    int unsigned full, mask;
    int sa, sb, ss, t;
    logic [W-1:0] e_sum;
    logic e_cout, e_ovf;
    full   = int'(a) + int'(b) + int'(cin);
    e_sum  = full[W-1:0];
    e_cout = full[W];
    sa = (a >= 128) ? int'(a) - 256 : int'(a);
    sb = (b >= 128) ? int'(b) - 256 : int'(b);
    ss = sa + sb + int'(cin);
    e_ovf = (ss > 127) || (ss < -128);

    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) begin check("ready_timeout", 0, 1); return; end

    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk);
    #1 in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);

    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      mask = (32'd1 << k) - 1;
      check("bit_valid", bit_valid, 1);
      check("a_bit", a_bit, a[k]);
      check("b_bit", b_bit, b[k]);
      check("c_bit", c_bit, (((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> k) & 1);
      check("out_valid_early", out_valid, 0);
    end

    @(negedge clk);
    check("out_valid", out_valid, 1);
    check("out_sum", out_sum, e_sum);
    check("out_cout", out_cout, e_cout);
    check("out_ovf", out_ovf, e_ovf);
    check("done_in_ready", in_ready, 0);
    check("done_busy", busy, 1);
    check("done_bit_valid", bit_valid, 0);

    // in_valid offered while holding must be ignored
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, e_sum);
      check("hold_cout", out_cout, e_cout);
      check("hold_ovf", out_ovf, e_ovf);
      check("hold_in_ready", in_ready, 0);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_bit_valid", bit_valid, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_out_sum", out_sum, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'h35, 8'h4A, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1);
    run_op(8'h7F, 8'h01, 1'b1, 5);
    run_op(8'h80, 8'h80, 1'b0, 0);

    // Reset in the 4th SHIFT cycle discards the operation
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'h66; in_cin = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_bit_valid", bit_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_bit_valid", bit_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(8'h10, 8'h20, 1'b0, 0);

    for (int i = 0; i < 1000; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), (($urandom % 4) == 0) ? int'($urandom_range(1, 4)) : 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, operand and sum width in bits; legal values are 2 to 32.
REQ-002 clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  an operand pair is offered.
REQ-005 in_ready  output  1  the block can accept an operand pair.
REQ-006 in_a, in_b  input  WIDTH  operands, treated as two's-complement for the overflow flag.
REQ-007 in_cin  input  1  carry-in for bit 0.
REQ-008 bit_valid  output  1  a_bit/b_bit/c_bit are valid this cycle.
REQ-009 a_bit, b_bit  output  1  current operand bits, sent LSB-first.
REQ-010 c_bit  output  1  carry into the current bit position.
REQ-011 sum_bit, carry_bit  input  1  combinational sum and carry-out returned by the external serial adder for the current bits.
REQ-012 out_valid  output  1  a result is held.
REQ-013 out_ready  input  1  the consumer accepts the result.
REQ-014 out_sum  output  WIDTH  sum.
REQ-015 out_cout  output  1  final carry-out.
REQ-016 out_ovf  output  1  signed overflow.
REQ-017 busy  output  1  the block is not in IDLE.

Function
REQ-018 The block SHALL implement a state machine with states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-019 In IDLE, when in_valid=1, the block SHALL latch in_a, in_b and in_cin into shift registers, clear the bit counter, and go to SHIFT.
REQ-020 In SHIFT, the block SHALL drive bit_valid=1, a_bit=a_sr[0] and b_bit=b_sr[0]; c_bit SHALL equal the latched in_cin at count 0, and the registered carry_bit from the previous bit otherwise.
REQ-021 On each SHIFT edge, the block SHALL:
 - shift sum_bit into result bit position count;
 - register carry_bit;
 - shift a_sr and b_sr right by one;
 - increment count.
REQ-022 After WIDTH SHIFT cycles (count reaches WIDTH-1 and is captured), the block SHALL go to DONE; out_cout SHALL be the last captured carry_bit.
REQ-023 out_ovf SHALL be 1 when in_a[WIDTH-1] equals in_b[WIDTH-1] and out_sum[WIDTH-1] differs from them; operand MSBs SHALL be retained for this purpose.
REQ-024 Latency: for an acceptance edge E, bits SHALL be presented in the W cycles following E, and out_valid SHALL rise in the cycle after edge E+W.
REQ-025 out_sum, out_cout and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 In DONE, when out_ready=1, the block SHALL go to IDLE; a new operand SHALL NOT be accepted in that same cycle, giving a minimum issue interval of W+2 cycles.
REQ-027 Outside SHIFT, bit_valid, a_bit, b_bit and c_bit SHALL be 0, and sum_bit/carry_bit SHALL be ignored.
REQ-028 in_valid SHALL be ignored in SHIFT and DONE, and out_ready SHALL be ignored in IDLE and SHIFT.
REQ-029 busy SHALL be 1 in SHIFT and DONE.

Reset
REQ-030 While reset=1, the block SHALL immediately go to IDLE and clear all outputs, shift registers, the counter and the carry to 0 (in_ready=1).
REQ-031 Reset asserted during SHIFT or DONE SHALL discard the operation with no result; after release, the first edge with in_valid=1 SHALL start a fresh operation.

Verification (bench models the adder as sum=a^b^c, carry=maj(a,b,c))
REQ-032 W=8, a=0x35, b=0x4A, cin=0 -> sum 0x7F, cout 0, ovf 0; out_valid rises in the cycle after edge E+8.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum 0x00, cout 1, ovf 0; c_bit=1 on bits 1..7.
REQ-034 a=0x7F, b=0x01, cin=1 -> sum 0x81, cout 0, ovf 1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 -> IDLE next edge; in_valid offered at that edge is not accepted.
REQ-036 Assert reset at the 4th SHIFT cycle -> bit_valid=0, busy=0 and in_ready=1 immediately; a subsequent 0x10+0x20 -> 0x30.
REQ-037 Back-to-back random stream of 1000 pairs with random out_ready stalls -> every result matches (a+b+cin) mod 256, with cout and ovf matching the reference model.
